// File: rtl/xilly_loop_fifo.sv
// Loopback FIFO between a Xillybus write stream and read stream on bus_clk.
// Standard (non-FWFT) read port, fill level, sticky overflow and optional EOF.
module xilly_loop_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 512,
    parameter int EOF_MODE = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              user_w_wren,
    input  logic [DATA_W-1:0] user_w_data,
    input  logic              user_w_open,
    output logic              user_w_full,
    input  logic              user_r_rden,
    output logic [DATA_W-1:0] user_r_data,
    output logic              user_r_empty,
    output logic              user_r_eof,
    input  logic              user_r_open,
    output logic [AW:0]       fill_level,
    output logic              overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              overflow_q, overflow_d;
    logic              w_open_q, w_open_d;
    logic              wr_closed_q, wr_closed_d;
    logic              eof_q, eof_d;

    logic clr;
    logic full;
    logic empty;
    logic wr_ok;
    logic rd_ok;
    logic w_fall;
    logic w_rise;

    // Flags come only from the registered count, never from the strobes.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        clr    = !bus_rst_n || (!user_w_open && !user_r_open);
        wr_ok  = user_w_wren && !full;
        rd_ok  = user_r_rden && !empty;
        w_fall = w_open_q && !user_w_open;
        w_rise = !w_open_q && user_w_open;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        overflow_d  = overflow_q;
        w_open_d    = user_w_open;
        wr_closed_d = wr_closed_q;
        eof_d       = 1'b0;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (user_w_wren && full) begin
            overflow_d = 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem[rd_ptr_q];
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (w_fall && user_r_open) begin
            wr_closed_d = 1'b1;
        end
        if (w_rise) begin
            wr_closed_d = 1'b0;
        end

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rdata_d     = '0;
            overflow_d  = 1'b0;
            wr_closed_d = 1'b0;
        end
        if (!bus_rst_n) begin
            w_open_d = 1'b0;
        end

        // EOF tracks the next-state count so it rises in step with empty.
        if (EOF_MODE != 0) begin
            eof_d = wr_closed_d && (count_d == '0);
        end
    end

    always_ff @(posedge bus_clk) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        rdata_q     <= rdata_d;
        overflow_q  <= overflow_d;
        w_open_q    <= w_open_d;
        wr_closed_q <= wr_closed_d;
        eof_q       <= eof_d;
    end

    always_ff @(posedge bus_clk) begin
        if (wr_ok && !clr) begin
            mem[wr_ptr_q] <= user_w_data;
        end
    end

    assign user_w_full  = full;
    assign user_r_empty = empty;
    assign user_r_data  = rdata_q;
    assign user_r_eof   = eof_q;
    assign fill_level   = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_xilly_loop_fifo.sv
// Bench for xilly_loop_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_xilly_loop_fifo;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AW = $clog2(DP);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          w_open;
    logic          rden;
    logic          r_open;

    logic          full1, empty1, eof1, ovf1;
    logic [DW-1:0] rdata1;
    logic [AW:0]   fill1;
    logic          full0, empty0, eof0, ovf0;
    logic [DW-1:0] rdata0;
    logic [AW:0]   fill0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xilly_loop_fifo #(.DATA_W(DW), .DEPTH(DP), .EOF_MODE(1)) dut (
        .bus_clk(clk), .bus_rst_n(rst_n),
        .user_w_wren(wren), .user_w_data(wdata), .user_w_open(w_open),
        .user_w_full(full1), .user_r_rden(rden), .user_r_data(rdata1),
        .user_r_empty(empty1), .user_r_eof(eof1), .user_r_open(r_open),
        .fill_level(fill1), .overflow(ovf1)
    );

    xilly_loop_fifo #(.DATA_W(DW), .DEPTH(DP), .EOF_MODE(0)) dut0 (
        .bus_clk(clk), .bus_rst_n(rst_n),
        .user_w_wren(wren), .user_w_data(wdata), .user_w_open(w_open),
        .user_w_full(full0), .user_r_rden(rden), .user_r_data(rdata0),
        .user_r_empty(empty0), .user_r_eof(eof0), .user_r_open(r_open),
        .fill_level(fill0), .overflow(ovf0)
    );

    // Reference model: contents as a queue, plus a few status bits.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;
    logic          m_ovf;
    logic          m_closed;
    logic          m_wprev;
    bit            checking = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit was_full;
        bit was_empty;
        if (!rst_n || (!w_open && !r_open)) begin
            if (!rst_n) checking = 1;
            q.delete();
            m_rdata  = '0;
            m_ovf    = 1'b0;
            m_closed = 1'b0;
            m_wprev  = rst_n ? w_open : 1'b0;
        end else begin
            was_full  = (q.size() == DP);
            was_empty = (q.size() == 0);
            if (rden && !was_empty) m_rdata = q.pop_front();
            if (wren) begin
                if (!was_full) q.push_back(wdata);
                else m_ovf = 1'b1;
            end
            if (m_wprev && !w_open && r_open) m_closed = 1'b1;
            if (!m_wprev && w_open) m_closed = 1'b0;
            m_wprev = w_open;
        end
        #1;
        if (checking) begin
            chk("m.empty", int'(empty1), int'(q.size() == 0));
            chk("m.full", int'(full1), int'(q.size() == DP));
            chk("m.fill", int'(fill1), q.size());
            chk("m.ovf", int'(ovf1), int'(m_ovf));
            chk("m.rdata", int'(rdata1), int'(m_rdata));
            chk("m.eof", int'(eof1), int'(m_closed && q.size() == 0));
            chk("m0.fill", int'(fill0), q.size());
            chk("m0.rdata", int'(rdata0), int'(m_rdata));
            chk("m0.ovf", int'(ovf0), int'(m_ovf));
            chk("m0.eof", int'(eof0), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wren = 1'b1;
        wdata = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic rd();
        rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wren = 1'b1;
        wdata = 8'hAA;
        rden = 1'b0;
        w_open = 1'b1;
        r_open = 1'b1;
        tick();
        tick();
        chk("rst.empty", int'(empty1), 1);
        chk("rst.full", int'(full1), 0);
        chk("rst.fill", int'(fill1), 0);
        chk("rst.ovf", int'(ovf1), 0);
        chk("rst.eof", int'(eof1), 0);
        rst_n = 1'b1;
        wren = 1'b0;
        tick();
        chk("rst.nowrite", int'(fill1), 0);

        for (int i = 0; i < 8; i++) wr(8'(8'h11 + i));
        chk("order.full", int'(full1), 1);
        chk("order.fill", int'(fill1), 8);
        for (int i = 0; i < 8; i++) begin
            rd();
            chk("order.data", int'(rdata1), 8'h11 + i);
        end
        chk("order.empty", int'(empty1), 1);

        for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
        for (int i = 0; i < 5; i++) begin
            rd();
            chk("wrap.data5", int'(rdata1), 8'h20 + i);
        end
        for (int i = 0; i < 8; i++) wr(8'(8'h30 + i));
        chk("wrap.full", int'(full1), 1);
        chk("wrap.ovf0", int'(ovf1), 0);
        wr(8'h99);
        chk("wrap.ovf", int'(ovf1), 1);
        chk("wrap.fill", int'(fill1), 8);

        wren = 1'b1;
        rden = 1'b1;
        wdata = 8'h77;
        tick();
        wren = 1'b0;
        rden = 1'b0;
        chk("sim_full.fill", int'(fill1), 7);
        chk("sim_full.ovf", int'(ovf1), 1);
        chk("sim_full.data", int'(rdata1), 8'h30);
        for (int i = 1; i < 8; i++) begin
            rd();
            chk("wrap.data8", int'(rdata1), 8'h30 + i);
        end
        chk("sim.empty", int'(empty1), 1);
        wren = 1'b1;
        rden = 1'b1;
        wdata = 8'h55;
        tick();
        wren = 1'b0;
        rden = 1'b0;
        chk("sim_empty.fill", int'(fill1), 1);
        chk("sim_empty.data", int'(rdata1), 8'h37);
        rd();
        chk("sim_empty.rd", int'(rdata1), 8'h55);
        rd();
        chk("rd_empty.hold", int'(rdata1), 8'h55);

        for (int i = 0; i < 3; i++) wr(8'(8'h61 + i));
        w_open = 1'b0;
        tick();
        chk("eof.closed", int'(eof1), 0);
        for (int i = 0; i < 3; i++) begin
            rd();
            chk("eof.data", int'(rdata1), 8'h61 + i);
            chk("eof.val", int'(eof1), int'(i == 2));
        end
        chk("eof.empty", int'(empty1), 1);
        chk("eof.mode0", int'(eof0), 0);
        tick();
        chk("eof.hold", int'(eof1), 1);
        w_open = 1'b1;
        tick();
        chk("eof.reopen", int'(eof1), 0);

        w_open = 1'b0;
        tick();
        chk("eof.close_empty", int'(eof1), 1);
        w_open = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) wr(8'(8'h40 + i));
        chk("flush.pre", int'(fill1), 4);
        chk("flush.pre_ovf", int'(ovf1), 1);
        w_open = 1'b0;
        r_open = 1'b0;
        tick();
        chk("flush.fill", int'(fill1), 0);
        chk("flush.empty", int'(empty1), 1);
        chk("flush.ovf", int'(ovf1), 0);
        chk("flush.data", int'(rdata1), 0);
        w_open = 1'b1;
        r_open = 1'b1;
        tick();

        wr(8'h81);
        wr(8'h82);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst.fill", int'(fill1), 0);
        chk("midrst.empty", int'(empty1), 1);
        wr(8'h90);
        rd();
        chk("midrst.data", int'(rdata1), 8'h90);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
